melody_sequencer: RTL

//  Plays a stored note sequence on the buzzer block by sequencing its toca and

---
 rtl/melody_sequencer_if.sv | 42 ++++
 rtl/melody_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/melody_sequencer_if.sv
// Bundle between the game FSM, the note memory and the buzzer.
// The sequencer takes the master side; the environment takes the slave side.
interface melody_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              iniciar;
    logic              parar;
    logic [ADDR_W:0]   tamanho;
    logic [ADDR_W-1:0] mem_endereco;
    logic [11:0]       mem_nota;
    logic [2:0]        mem_duracao;
    logic [11:0]       seletor;
    logic              toca;
    logic              tocando;
    logic              pronto;

    modport master (
        input  iniciar,
        input  parar,
        input  tamanho,
        input  mem_nota,
        input  mem_duracao,
        output mem_endereco,
        output seletor,
        output toca,
        output tocando,
        output pronto
    );

    modport slave (
        output iniciar,
        output parar,
        output tamanho,
        output mem_nota,
        output mem_duracao,
        input  mem_endereco,
        input  seletor,
        input  toca,
        input  tocando,
        input  pronto
    );
endinterface

// File: rtl/melody_sequencer.sv
// Steps through a stored melody, driving the buzzer note select and enable.
// Each note plays for (duracao+1) tempo units, then a fixed silence gap.
module melody_sequencer #(
    parameter int CLOCK_FREQ   = 50_000_000,
    parameter int TEMPO_CYCLES = 6_250_000,
    parameter int GAP_CYCLES   = 2_500_000,
    parameter int ADDR_W       = 4
) (
    input  logic                clock,
    input  logic                reset,
    melody_sequencer_if.master  bus
);

    localparam int MAXC = (8 * TEMPO_CYCLES > GAP_CYCLES)
                          ? 8 * TEMPO_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] TEMPO_W  = CW'(TEMPO_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || TEMPO_CYCLES < 1 || CLOCK_FREQ < 1) begin : g_param_err
        $error("melody_sequencer: GAP/TEMPO/CLOCK_FREQ must be >= 1");
    end

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGA,
        TOCA_NOTA,
        PAUSA,
        PROXIMA,
        FIM
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       sel_q, sel_d;
    logic              toca_q, toca_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [CW-1:0]     note_load;
    logic              last_note;

    // Counter runs down to zero, so load one less than the cycle count.
    assign note_load = (({{(CW-3){1'b0}}, bus.mem_duracao} + CW'(1))
                        * TEMPO_W) - CW'(1);

    assign last_note = ({1'b0, addr_q} == (bus.tamanho - 1'b1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= OCIOSO;
            addr_q  <= '0;
            sel_q   <= '0;
            toca_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            toca_q  <= toca_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        toca_d  = toca_q;
        cnt_d   = cnt_q;

        if (state_q != OCIOSO && bus.parar) begin
            state_d = OCIOSO;
            addr_d  = '0;
            sel_d   = '0;
            toca_d  = 1'b0;
        end else begin
            unique case (state_q)
                OCIOSO: begin
                    if (bus.iniciar && !bus.parar) begin
                        addr_d  = '0;
                        state_d = (bus.tamanho == '0) ? FIM : CARREGA;
                    end
                end
                CARREGA: begin
                    sel_d   = bus.mem_nota;
                    toca_d  = |bus.mem_nota;
                    cnt_d   = note_load;
                    state_d = TOCA_NOTA;
                end
                TOCA_NOTA: begin
                    if (cnt_q == '0) begin
                        toca_d  = 1'b0;
                        cnt_d   = GAP_LOAD;
                        state_d = PAUSA;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PAUSA: begin
                    if (cnt_q == '0) begin
                        state_d = PROXIMA;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PROXIMA: begin
                    if (last_note) begin
                        state_d = FIM;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = CARREGA;
                    end
                end
                FIM: begin
                    addr_d  = '0;
                    state_d = OCIOSO;
                end
                default: begin
                    state_d = OCIOSO;
                end
            endcase
        end
    end

    assign bus.mem_endereco = addr_q;
    assign bus.seletor      = sel_q;
    assign bus.toca         = toca_q;
    assign bus.tocando      = (state_q != OCIOSO);
    // A simultaneous abort in FIM must swallow the completion pulse.
    assign bus.pronto       = (state_q == FIM) && !bus.parar;

endmodule
